alu_share_arbiter: RTL

- Shares one ALU instance (9-bit operands, 3-bit opcode) between two requesters: req0 is the execute stage, req1 is the load/store address-generation unit.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; operands registered into the ALU, ALU outputs captured and held until the owner consumes them.
- Sits between the decode/execute logic and the combinational ALU.

---
 rtl/alu_share_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between execute and AGU requesters
// Optional per-requester grant counters are built when ALU_SHARE_ARBITER_CNT_EN is defined.
`timescale 1ns/1ps
module alu_share_arbiter #(
  parameter int REG_WIDTH = 9,
  parameter int OP_WIDTH  = 3,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OP_WIDTH-1:0]  req0_op,
  input  logic [REG_WIDTH-1:0] req0_a,
  input  logic [REG_WIDTH-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OP_WIDTH-1:0]  req1_op,
  input  logic [REG_WIDTH-1:0] req1_a,
  input  logic [REG_WIDTH-1:0] req1_b,
  output logic                 resp0_valid,
  input  logic                 resp0_ready,
  output logic [REG_WIDTH-1:0] resp0_res,
  output logic [REG_WIDTH-1:0] resp0_car,
  output logic                 resp0_zero,
  output logic                 resp0_jump,
  output logic                 resp1_valid,
  input  logic                 resp1_ready,
  output logic [REG_WIDTH-1:0] resp1_res,
  output logic [REG_WIDTH-1:0] resp1_car,
  output logic                 resp1_zero,
  output logic                 resp1_jump,
  output logic [REG_WIDTH-1:0] alu_ra,
  output logic [REG_WIDTH-1:0] alu_rb,
  output logic [OP_WIDTH-1:0]  alu_op,
`ifdef ALU_SHARE_ARBITER_CNT_EN
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] grant_cnt0,
  output logic [CNT_WIDTH-1:0] grant_cnt1,
`endif
  input  logic [REG_WIDTH-1:0] alu_res,
  input  logic [REG_WIDTH-1:0] alu_car,
  input  logic                 alu_zero,
  input  logic                 alu_jump
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t                      r_state;
  logic                        r_owner;
  logic                        r_rr_ptr;
  logic [1:0]                  r_resp_valid;
  logic [1:0][REG_WIDTH-1:0]   r_res;
  logic [1:0][REG_WIDTH-1:0]   r_car;
  logic [1:0]                  r_zero;
  logic [1:0]                  r_jump;
  logic [REG_WIDTH-1:0]        r_alu_ra;
  logic [REG_WIDTH-1:0]        r_alu_rb;
  logic [OP_WIDTH-1:0]         r_alu_op;

  logic                        w_grant_vld;
  logic                        w_grant;
  logic                        w_resp_hs;
  logic                        w_op_undef;
  logic                        w_op_car;
  logic                        w_op_jump;
  logic [REG_WIDTH-1:0]        w_cap_res;
  logic [REG_WIDTH-1:0]        w_cap_car;
  logic                        w_cap_zero;
  logic                        w_cap_jump;

  // On a tie the requester that did not win last time gets the ALU.
  assign w_grant_vld = req0_valid | req1_valid;
  assign w_grant     = (req0_valid && req1_valid) ? ~r_rr_ptr : req1_valid;
  assign req0_ready  = (r_state == S_IDLE) && w_grant_vld && !w_grant;
  assign req1_ready  = (r_state == S_IDLE) && w_grant_vld &&  w_grant;
  assign w_resp_hs   = r_owner ? resp1_ready : resp0_ready;

  assign w_op_undef  = (r_alu_op == OP_WIDTH'(7));
  assign w_op_car    = (r_alu_op == OP_WIDTH'(2)) || (r_alu_op == OP_WIDTH'(3)) ||
                       (r_alu_op == OP_WIDTH'(4));
  assign w_op_jump   = (r_alu_op == OP_WIDTH'(5));
  assign w_cap_res   = w_op_undef ? '0 : alu_res;
  assign w_cap_car   = w_op_car ? alu_car : '0;
  assign w_cap_jump  = w_op_jump ? alu_jump : 1'b0;
  assign w_cap_zero  = w_op_undef ? 1'b1 : alu_zero;

  assign alu_ra      = r_alu_ra;
  assign alu_rb      = r_alu_rb;
  assign alu_op      = r_alu_op;
  assign resp0_valid = r_resp_valid[0];
  assign resp1_valid = r_resp_valid[1];
  assign resp0_res   = r_res[0];
  assign resp0_car   = r_car[0];
  assign resp0_zero  = r_zero[0];
  assign resp0_jump  = r_jump[0];
  assign resp1_res   = r_res[1];
  assign resp1_car   = r_car[1];
  assign resp1_zero  = r_zero[1];
  assign resp1_jump  = r_jump[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_rr_ptr     <= 1'b1;
      r_resp_valid <= '0;
      r_res        <= '0;
      r_car        <= '0;
      r_zero       <= '0;
      r_jump       <= '0;
      r_alu_ra     <= '0;
      r_alu_rb     <= '0;
      r_alu_op     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_alu_op <= w_grant ? req1_op : req0_op;
            r_alu_ra <= w_grant ? req1_a  : req0_a;
            r_alu_rb <= w_grant ? req1_b  : req0_b;
            r_owner  <= w_grant;
            r_rr_ptr <= w_grant;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_res[r_owner]        <= w_cap_res;
          r_car[r_owner]        <= w_cap_car;
          r_zero[r_owner]       <= w_cap_zero;
          r_jump[r_owner]       <= w_cap_jump;
          r_resp_valid[r_owner] <= 1'b1;
          r_state               <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_hs) begin
            r_resp_valid <= '0;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_ARBITER_CNT_EN
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;

  // Clear has priority over a same-cycle grant; counts saturate at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + 1'b1;
      if (req1_valid && req1_ready && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end
`endif

endmodule
